// File: rtl/pdp8l_iot_pkg.sv
// ---------------------------------------------------------------------------
// pdp8l_iot_pkg
// Shared definitions for the PDP-8/L IOT initiator (CPU-side IOP sequencer):
//   - iot_state_t : sequencer state encoding
//   - IOP1/IOP2/IOP4 : one-hot pulse selects placed in ioopcode[2:0]
//   - IOT_OP      : opcode[11:9] value identifying an IOT instruction
//   - next_pulse  : picks the next pulse to issue (lowest pending bit first,
//                   giving the hardware order IOP1, IOP2, IOP4)
// ---------------------------------------------------------------------------
package pdp8l_iot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PSTART = 3'd1,
        ST_PHOLD  = 3'd2,
        ST_PSTOP  = 3'd3,
        ST_PGAP   = 3'd4,
        ST_FIN    = 3'd5
    } iot_state_t;

    localparam logic [2:0] IOP1   = 3'b001;
    localparam logic [2:0] IOP2   = 3'b010;
    localparam logic [2:0] IOP4   = 3'b100;
    localparam logic [2:0] IOT_OP = 3'o6;

    // Lowest set bit of the pending mask, or 0 when nothing is pending.
    function automatic logic [2:0] next_pulse(input logic [2:0] pending);
        logic [2:0] sel;
        sel = 3'b000;
        if (pending[0]) begin
            sel = IOP1;
        end else if (pending[1]) begin
            sel = IOP2;
        end else if (pending[2]) begin
            sel = IOP4;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pdp8l_iot_initiator.sv
// ---------------------------------------------------------------------------
// pdp8l_iot_initiator
// Bus-master side of the PDP-8/L I/O pulse interface. Executes one IOT
// instruction as a sequence of IOP1/IOP2/IOP4 pulses on the
// iopstart/iopstop/ioopcode/cputodev bus, folds the device responses into
// the AC and returns the final AC plus the accumulated skip flag.
//
// Ports:
//   CLOCK, RESET        clock, synchronous active-high reset
//   start/opcode/acin   request (accepted only while idle)
//   busy                sequence in progress (cycle after start .. FIN)
//   done                one-cycle completion strobe
//   acout/skip          result, valid from done, held afterwards
//   iopstart/iopstop    one-cycle leading / trailing edge of each IOP
//   ioopcode            {opcode[11:3], pulse bit}
//   cputodev            running AC presented to the device during a pulse
//   devtocpu/AC_CLEAR/IO_SKIP  device responses, sampled on the last hold cycle
//   INT_RQST/intrq      interrupt request, registered one cycle
//
// Per pulse: PSTART(1) + PHOLD(PULSEW) + PSTOP(1) + PGAP(GAPW) cycles.
// ---------------------------------------------------------------------------
module pdp8l_iot_initiator
    import pdp8l_iot_pkg::*;
#(
    parameter int PULSEW = 4,
    parameter int GAPW   = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic [11:0] opcode,
    input  logic [11:0] acin,
    output logic        busy,
    output logic        done,
    output logic [11:0] acout,
    output logic        skip,
    output logic        iopstart,
    output logic        iopstop,
    output logic [11:0] ioopcode,
    output logic [11:0] cputodev,
    input  logic [11:0] devtocpu,
    input  logic        AC_CLEAR,
    input  logic        IO_SKIP,
    input  logic        INT_RQST,
    output logic        intrq
);

    localparam int CNT_MAX = (PULSEW > GAPW) ? PULSEW : GAPW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    iot_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [8:0]        op_reg;        // opcode[11:3], device + IOT field
    logic [11:0]       ac_reg;        // running AC across pulses
    logic              skip_acc_reg;
    logic [2:0]        pending_reg;   // pulses still to issue
    logic [2:0]        sel_reg;       // pulse currently on the bus

    logic [2:0]        first_sel;
    logic [2:0]        next_sel;
    logic              is_iot;

    assign is_iot    = (opcode[11:9] == IOT_OP) && (opcode[2:0] != 3'b000);
    assign first_sel = next_pulse(opcode[2:0]);
    assign next_sel  = next_pulse(pending_reg);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            ac_reg       <= '0;
            skip_acc_reg <= 1'b0;
            pending_reg  <= '0;
            sel_reg      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            acout        <= '0;
            skip         <= 1'b0;
            iopstart     <= 1'b0;
            iopstop      <= 1'b0;
            ioopcode     <= '0;
            cputodev     <= '0;
            intrq        <= 1'b0;
        end else begin
            // Interrupt request is just re-timed; it does not interact with
            // the pulse sequencing.
            intrq <= INT_RQST;
            done  <= 1'b0;

            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        op_reg       <= opcode[11:3];
                        ac_reg       <= acin;
                        skip_acc_reg <= 1'b0;
                        pending_reg  <= opcode[2:0];
                        cnt_reg      <= '0;
                        if (is_iot) begin
                            state_reg <= ST_PSTART;
                            sel_reg   <= first_sel;
                            iopstart  <= 1'b1;
                            ioopcode  <= {opcode[11:3], first_sel};
                            cputodev  <= acin;
                        end else begin
                            // Nothing to pulse: complete with AC unchanged.
                            state_reg <= ST_FIN;
                            done      <= 1'b1;
                            acout     <= acin;
                            skip      <= 1'b0;
                        end
                    end
                end

                ST_PSTART: begin
                    iopstart  <= 1'b0;
                    state_reg <= ST_PHOLD;
                    cnt_reg   <= CNT_W'(PULSEW - 1);
                end

                ST_PHOLD: begin
                    if (cnt_reg == '0) begin
                        // Last hold cycle: device outputs are settled.
                        ac_reg       <= (AC_CLEAR ? 12'o0000 : ac_reg) | devtocpu;
                        skip_acc_reg <= skip_acc_reg | IO_SKIP;
                        iopstop      <= 1'b1;
                        state_reg    <= ST_PSTOP;
                        cnt_reg      <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_PSTOP: begin
                    iopstop     <= 1'b0;
                    ioopcode    <= '0;
                    cputodev    <= '0;
                    pending_reg <= pending_reg & ~sel_reg;
                    state_reg   <= ST_PGAP;
                    cnt_reg     <= CNT_W'(GAPW - 1);
                end

                ST_PGAP: begin
                    if (cnt_reg == '0) begin
                        cnt_reg <= '0;
                        if (pending_reg != 3'b000) begin
                            // Later pulses present the AC as modified so far.
                            state_reg <= ST_PSTART;
                            sel_reg   <= next_sel;
                            iopstart  <= 1'b1;
                            ioopcode  <= {op_reg, next_sel};
                            cputodev  <= ac_reg;
                        end else begin
                            state_reg <= ST_FIN;
                            done      <= 1'b1;
                            acout     <= ac_reg;
                            skip      <= skip_acc_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_FIN: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    iopstart  <= 1'b0;
                    iopstop   <= 1'b0;
                end
            endcase
        end
    end

endmodule
